// File: rtl/sram_test_pkg.sv
// Shared types for the March C- BIST: FSM states, per-op descriptor and the
// element table that says which way each element walks and what it does.
package sram_test_pkg;

    typedef enum logic [3:0] {
        IDLE,
        M0,
        M1,
        M2,
        M3,
        M4,
        M5,
        DRAIN,
        DONE
    } march_state_e;

    typedef struct packed {
        logic is_write;
        logic data_one;
    } march_op_t;

    typedef struct packed {
        logic      down;
        logic      two_ops;
        march_op_t op0;
        march_op_t op1;
    } march_elem_t;

    localparam march_op_t OP_W0 = '{is_write: 1'b1, data_one: 1'b0};
    localparam march_op_t OP_W1 = '{is_write: 1'b1, data_one: 1'b1};
    localparam march_op_t OP_R0 = '{is_write: 1'b0, data_one: 1'b0};
    localparam march_op_t OP_R1 = '{is_write: 1'b0, data_one: 1'b1};

    // March C- element table; non-element states return an inert entry.
    function automatic march_elem_t march_elem(input march_state_e s);
        march_elem_t e;
        e = '{1'b0, 1'b0, OP_W0, OP_W0};
        case (s)
            M0:      e = '{1'b0, 1'b0, OP_W0, OP_W0};
            M1:      e = '{1'b0, 1'b1, OP_R0, OP_W1};
            M2:      e = '{1'b0, 1'b1, OP_R1, OP_W0};
            M3:      e = '{1'b1, 1'b1, OP_R0, OP_W1};
            M4:      e = '{1'b1, 1'b1, OP_R1, OP_W0};
            M5:      e = '{1'b0, 1'b0, OP_R0, OP_R0};
            default: e = '{1'b0, 1'b0, OP_W0, OP_W0};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/sram_march_bist_if.sv
// Macro-side port bundle of one GF180 SRAM bank: the BIST is the master.
interface sram_march_bist_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
);
    logic              sram_cen;
    logic              sram_gwen;
    logic [DATA_W-1:0] sram_wen;
    logic [ADDR_W-1:0] sram_a;
    logic [DATA_W-1:0] sram_d;
    logic [DATA_W-1:0] sram_q;

    modport master (
        output sram_cen, sram_gwen, sram_wen, sram_a, sram_d,
        input  sram_q
    );

    modport slave (
        input  sram_cen, sram_gwen, sram_wen, sram_a, sram_d,
        output sram_q
    );
endinterface

// File: rtl/sram_bist_addr_gen.sv
// Up/down address counter for march elements; 'last' flags the terminal
// address of the current direction.
module sram_bist_addr_gen #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              load_down,
    input  logic              step,
    input  logic              down,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] addr_q, addr_d;

    always_comb begin
        addr_d = addr_q;
        if (load) begin
            addr_d = load_down ? ADDR_MAX : '0;
        end else if (step) begin
            addr_d = down ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr = addr_q;
    assign last = down ? (addr_q == '0) : (addr_q == ADDR_MAX);
endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST engine for one SRAM bank: FSM, read-compare pipeline, error counter.
// Optional first-failure log enabled by defining SRAM_BIST_FAILLOG_EN.
module sram_march_bist
    import sram_test_pkg::*;
#(
    parameter int                DEPTH  = 512,
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] BG     = '0,
    parameter int                ERR_W  = 16,
    localparam int               ADDR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_count,
    sram_march_bist_if.master  mem
`ifdef SRAM_BIST_FAILLOG_EN
    ,
    output logic [ADDR_W-1:0]  fail_addr,
    output logic [DATA_W-1:0]  fail_data
`endif
);
    march_state_e      state_q, state_d, elem_next;
    march_elem_t       elem, elem_nx;
    march_op_t         op;
    logic              phase_q, phase_d;
    logic              op_active, start_accept, mismatch;
    logic              cmp_valid_q, cmp_valid_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              pass_q, pass_d;
    logic [ADDR_W-1:0] addr;
    logic              addr_last, ag_load, ag_load_down, ag_step;

    assign elem      = march_elem(state_q);
    assign elem_next = march_state_e'(state_q + 4'd1);
    assign elem_nx   = march_elem(elem_next);
    assign mismatch  = cmp_valid_q && (mem.sram_q != exp_q);

    sram_bist_addr_gen #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ag_load),
        .load_down (ag_load_down),
        .step      (ag_step),
        .down      (elem.down),
        .addr      (addr),
        .last      (addr_last)
    );

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        op           = elem.op0;
        op_active    = 1'b0;
        start_accept = 1'b0;
        ag_load      = 1'b0;
        ag_load_down = 1'b0;
        ag_step      = 1'b0;
        cmp_valid_d  = 1'b0;
        exp_d        = exp_q;
        pass_d       = pass_q;
        err_d        = err_q;
        if (mismatch && (err_q != '1)) begin
            err_d = err_q + ERR_W'(1);
        end
        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    state_d = IDLE;
                end
                if (start) begin
                    start_accept = 1'b1;
                    state_d      = M0;
                    phase_d      = 1'b0;
                    ag_load      = 1'b1;
                    err_d        = '0;
                    pass_d       = 1'b0;
                end
            end
            DRAIN: begin
                // Final M5 compare lands in err_d this cycle.
                state_d = DONE;
                pass_d  = (err_d == '0);
            end
            default: begin
                op_active = 1'b1;
                op        = phase_q ? elem.op1 : elem.op0;
                if (elem.two_ops && !phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (addr_last) begin
                        state_d      = elem_next;
                        ag_load      = 1'b1;
                        ag_load_down = elem_nx.down;
                    end else begin
                        ag_step = 1'b1;
                    end
                end
                if (!op.is_write) begin
                    cmp_valid_d = 1'b1;
                    exp_d       = op.data_one ? ~BG : BG;
                end
            end
        endcase
    end

    always_comb begin
        mem.sram_cen  = 1'b1;
        mem.sram_gwen = 1'b1;
        mem.sram_wen  = '1;
        mem.sram_a    = '0;
        mem.sram_d    = '0;
        if (op_active) begin
            mem.sram_cen = 1'b0;
            mem.sram_a   = addr;
            if (op.is_write) begin
                mem.sram_gwen = 1'b0;
                mem.sram_wen  = '0;
                mem.sram_d    = op.data_one ? ~BG : BG;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            phase_q     <= 1'b0;
            cmp_valid_q <= 1'b0;
            exp_q       <= '0;
            err_q       <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cmp_valid_q <= cmp_valid_d;
            exp_q       <= exp_d;
            err_q       <= err_d;
            pass_q      <= pass_d;
        end
    end

    assign busy      = (state_q != IDLE) && (state_q != DONE);
    assign done      = (state_q == DONE);
    assign pass      = pass_q;
    assign err_count = err_q;

`ifdef SRAM_BIST_FAILLOG_EN
    logic              fail_seen_q, fail_seen_d;
    logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d, fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_data_q, fail_data_d;

    always_comb begin
        cmp_addr_d  = (op_active && !op.is_write) ? addr : cmp_addr_q;
        fail_seen_d = fail_seen_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        if (start_accept) begin
            fail_seen_d = 1'b0;
            fail_addr_d = '0;
            fail_data_d = '0;
        end else if (mismatch && !fail_seen_q) begin
            fail_seen_d = 1'b1;
            fail_addr_d = cmp_addr_q;
            fail_data_d = mem.sram_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fail_seen_q <= 1'b0;
            cmp_addr_q  <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else begin
            fail_seen_q <= fail_seen_d;
            cmp_addr_q  <= cmp_addr_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
        end
    end

    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
`endif
endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: DEPTH=64 DUT on a faulty macro model, plus an
// ERR_W=4 DUT on a constant-Q macro for counter saturation.
module tb_sram_march_bist;
    localparam int         D    = 64;
    localparam int         AW   = 6;
    localparam int         NOPS = 10 * D;
    localparam logic [7:0] BG   = 8'h00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy1, done1, pass1, busy2, done2, pass2;
    logic [15:0] err1;
    logic [3:0]  err2;
`ifdef SRAM_BIST_FAILLOG_EN
    logic [AW-1:0] fa1, fa2;
    logic [7:0]    fd1, fd2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_march_bist_if #(.ADDR_W(AW), .DATA_W(8)) bus1 ();
    sram_march_bist_if #(.ADDR_W(AW), .DATA_W(8)) bus2 ();

    sram_march_bist #(.DEPTH(D), .DATA_W(8), .BG(BG), .ERR_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy1), .done(done1),
        .pass(pass1), .err_count(err1), .mem(bus1)
`ifdef SRAM_BIST_FAILLOG_EN
        , .fail_addr(fa1), .fail_data(fd1)
`endif
    );

    sram_march_bist #(.DEPTH(D), .DATA_W(8), .BG(BG), .ERR_W(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy2), .done(done2),
        .pass(pass2), .err_count(err2), .mem(bus2)
`ifdef SRAM_BIST_FAILLOG_EN
        , .fail_addr(fa2), .fail_data(fd2)
`endif
    );

    // Macro model: one-cycle read, per-bit write enable, one faulty cell.
    logic [7:0] mem_arr [D];
    bit         f_en = 1'b0;
    int         f_addr = 0;
    logic [7:0] f_sa0 = 8'h00;
    logic [7:0] f_sa1 = 8'h00;

    function automatic logic [7:0] faulty(input int a, input logic [7:0] v);
        return (f_en && a == f_addr) ? ((v & ~f_sa0) | f_sa1) : v;
    endfunction

    always @(posedge clk) begin
        if (!bus1.sram_cen) begin
            if (!bus1.sram_gwen)
                mem_arr[bus1.sram_a] <= (mem_arr[bus1.sram_a] & bus1.sram_wen) | (bus1.sram_d & ~bus1.sram_wen);
            else
                bus1.sram_q <= faulty(int'(bus1.sram_a), mem_arr[bus1.sram_a]);
        end
    end
    assign bus2.sram_q = 8'hA5;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Operation k (1..10*D) of March C-, from the element layout.
    function automatic void op_at(input int kk, output bit w, output int addr, output logic [7:0] data);
        int t, e, r, i;
        logic [7:0] rd;
        t = kk - 1;
        if (t < D) begin
            w = 1'b1; addr = t; data = BG;
        end else if (t < 9 * D) begin
            t = t - D;
            e = t / (2 * D);
            r = t % (2 * D);
            i = r / 2;
            rd = (e % 2 == 1) ? ~BG : BG;
            addr = (e >= 2) ? (D - 1 - i) : i;
            w = (r % 2 == 1);
            data = w ? ~rd : rd;
        end else begin
            w = 1'b0; addr = t - 9 * D; data = BG;
        end
    endfunction

    // Reference model: k = cycle index of the run (1-based), -1 when idle.
    int         k = -1;
    int         exp_err = 0, exp_err2 = 0;
    bit         exp_pass = 1'b0, exp_pass2 = 1'b0, model_ready = 1'b0;
    bit         exp_fseen = 1'b0;
    int         exp_fa = 0;
    logic [7:0] exp_fd = 8'h00;

    initial begin
        bit m_w;
        int m_a;
        logic [7:0] m_d;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                k = -1; exp_err = 0; exp_err2 = 0; exp_pass = 0; exp_pass2 = 0;
                exp_fseen = 0; exp_fa = 0; exp_fd = 8'h00; model_ready = 1;
            end else begin
                if (k >= 2 && k <= NOPS + 1) begin
                    op_at(k - 1, m_w, m_a, m_d);
                    if (!m_w) begin
                        if (exp_err2 < 15) exp_err2++;
                        if (faulty(m_a, m_d) != m_d) begin
                            if (exp_err < 65535) exp_err++;
                            if (!exp_fseen) begin
                                exp_fseen = 1; exp_fa = m_a; exp_fd = faulty(m_a, m_d);
                            end
                        end
                    end
                end
                if (k == NOPS + 1) begin
                    k = NOPS + 2; exp_pass = (exp_err == 0); exp_pass2 = (exp_err2 == 0);
                end else if ((k == -1 || k == NOPS + 2) && start) begin
                    k = 1; exp_err = 0; exp_err2 = 0; exp_pass = 0; exp_pass2 = 0;
                    exp_fseen = 0; exp_fa = 0; exp_fd = 8'h00;
                end else if (k == NOPS + 2) begin
                    k = -1;
                end else if (k >= 1) begin
                    k++;
                end
            end
        end
    end

    // Per-cycle compare of both DUTs against the model.
    initial begin
        bit c_w;
        int c_a;
        logic [7:0] c_dv, e_wen, e_d;
        logic [AW-1:0] e_a;
        logic e_cen, e_gwen, e_busy, e_done;
        forever begin
            @(negedge clk);
            if (model_ready) begin
                e_cen = 1; e_gwen = 1; e_wen = 8'hFF; e_a = '0; e_d = 8'h00;
                if (k >= 1 && k <= NOPS) begin
                    op_at(k, c_w, c_a, c_dv);
                    e_cen = 0; e_gwen = !c_w; e_a = AW'(c_a);
                    e_wen = c_w ? 8'h00 : 8'hFF;
                    e_d = c_w ? c_dv : 8'h00;
                end
                e_busy = (k >= 1 && k <= NOPS + 1);
                e_done = (k == NOPS + 2);
                chk($sformatf("cycle_outputs k=%0d", k),
                    64'({busy1, done1, pass1, err1, bus1.sram_cen, bus1.sram_gwen, bus1.sram_wen,
                         bus1.sram_a, bus1.sram_d, busy2, done2, pass2, err2}),
                    64'({e_busy, e_done, exp_pass, 16'(exp_err), e_cen, e_gwen, e_wen,
                         e_a, e_d, e_busy, e_done, exp_pass2, 4'(exp_err2)}));
`ifdef SRAM_BIST_FAILLOG_EN
                chk("faillog", 64'({fa1, fd1}), 64'({AW'(exp_fa), exp_fd}));
`endif
            end
        end
    end

    task automatic run(input int restart_at, input int rst_at, input bit trace,
                       output int done_cyc, output int busy_cnt, output int wr0, output int wrf);
        done_cyc = -1; busy_cnt = 0; wr0 = 0; wrf = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 700; c++) begin
            if (busy1) busy_cnt++;
            if (!bus1.sram_cen && !bus1.sram_gwen) begin
                if (bus1.sram_d == 8'h00) wr0++;
                else if (bus1.sram_d == 8'hFF) wrf++;
            end
            if (c == 1) chk("start_clears", 64'({pass1, err1}), 64'(0));
            if (trace) begin
                if (c == 1)   chk("m0_first_op", 64'({bus1.sram_cen, bus1.sram_gwen, bus1.sram_a, bus1.sram_d}), 64'({1'b0, 1'b0, 6'd0, 8'h00}));
                if (c == 65)  chk("m1_first_read", 64'({bus1.sram_gwen, bus1.sram_a}), 64'({1'b1, 6'd0}));
                if (c == 66)  chk("m1_first_write", 64'({bus1.sram_gwen, bus1.sram_a, bus1.sram_d}), 64'({1'b0, 6'd0, 8'hFF}));
                if (c == 321) chk("m3_first_read", 64'({bus1.sram_gwen, bus1.sram_a}), 64'({1'b1, 6'd63}));
                if (c == 448) chk("m3_last_write", 64'({bus1.sram_gwen, bus1.sram_a}), 64'({1'b0, 6'd0}));
            end
            if (rst_at > 0 && c == rst_at + 1)
                chk("abort_idle", 64'({bus1.sram_cen, bus1.sram_gwen, busy1, err1}), 64'({1'b1, 1'b1, 1'b0, 16'd0}));
            if (done1) begin
                done_cyc = c;
                break;
            end
            start = (c == restart_at);
            rst_n = !(rst_at > 0 && c == rst_at);
            @(negedge clk);
        end
        start = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        int dc, bc, w0, wf, lit;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_err", 64'(err1), 64'(0));
        chk("reset_pass_busy_done", 64'({pass1, busy1, done1}), 64'(0));
        chk("reset_macro_idle", 64'({bus1.sram_cen, bus1.sram_gwen, bus1.sram_wen, bus1.sram_a, bus1.sram_d}),
            64'({1'b1, 1'b1, 8'hFF, 6'd0, 8'h00}));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Fault-free run with trace checks; DUT2 saturates on constant Q.
        run(0, 0, 1'b1, dc, bc, w0, wf);
        chk("t1_done_cycle", 64'(dc), 64'(642));
        chk("t1_busy_cycles", 64'(bc), 64'(641));
        chk("t1_pass_err", 64'({pass1, err1}), 64'({1'b1, 16'd0}));
        chk("t6_writes_00", 64'(w0), 64'(192));
        chk("t6_writes_ff", 64'(wf), 64'(128));
        chk("t5_err_saturated", 64'({pass2, err2}), 64'({1'b0, 4'hF}));
        repeat (2) @(negedge clk);

        // Bit 3 stuck-at-0 at address 5.
        f_en = 1; f_addr = 5; f_sa0 = 8'h08; f_sa1 = 8'h00;
        run(0, 0, 1'b0, dc, bc, w0, wf);
        chk("t2_done_cycle", 64'(dc), 64'(642));
        chk("t2_pass_err", 64'({pass1, err1}), 64'({1'b0, 16'd2}));
`ifdef SRAM_BIST_FAILLOG_EN
        chk("t2_faillog", 64'({fa1, fd1}), 64'({6'd5, 8'hF7}));
`endif
        repeat (3) @(negedge clk);

        // Restart mid-run is ignored; restart in the DONE cycle is taken.
        f_en = 0;
        run(100, 0, 1'b0, dc, bc, w0, wf);
        chk("t3_done_cycle", 64'(dc), 64'(642));
        run(0, 0, 1'b0, dc, bc, w0, wf);
        chk("t3_rerun_done_cycle", 64'(dc), 64'(642));
        chk("t3_rerun_pass_err", 64'({pass1, err1}), 64'({1'b1, 16'd0}));
        @(negedge clk);

        // Reset at cycle 300 of a faulty run aborts without done.
        f_en = 1; f_addr = 5; f_sa0 = 8'h08; f_sa1 = 8'h00;
        run(0, 300, 1'b0, dc, bc, w0, wf);
        chk("t4_no_done", 64'(dc), 64'(-1));

        // Random single-cell faults: sa0 gives 2 errors, sa1 gives 3 (BG=00).
        for (int r = 0; r < 4; r++) begin
            f_en = ($urandom_range(0, 3) != 0);
            f_addr = $urandom_range(0, D - 1);
            if ($urandom_range(0, 1) == 1) begin
                f_sa0 = 8'($urandom_range(1, 255)); f_sa1 = 8'h00;
            end else begin
                f_sa0 = 8'h00; f_sa1 = 8'($urandom_range(1, 255));
            end
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run(0, 0, 1'b0, dc, bc, w0, wf);
            lit = !f_en ? 0 : ((f_sa0 != 8'h00) ? 2 : 3);
            chk($sformatf("rand%0d_done_cycle", r), 64'(dc), 64'(642));
            chk($sformatf("rand%0d_err", r), 64'({pass1, err1}), 64'({lit == 0, 16'(lit)}));
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
